// File: rtl/alu_pkg.sv
// Shared types and default widths for the ALU sequencer slice.
package alu_pkg;

   localparam int W   = 8;
   localparam int Ops = 3;

   typedef enum logic [2:0] {
      ADD = 3'b000,
      SHR = 3'b001,
      SHL = 3'b010,
      PAR = 3'b011,
      MOV = 3'b100
   } opcode_e;

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_B,
      EXEC,
      WB,
      ILL
   } state_e;

endpackage

// File: rtl/alu_inst_decode.sv
// Combinational opcode decode: legality, ALU opcode, A-forcing and B-masking.
module alu_inst_decode
   import alu_pkg::*;
#(
   parameter int OpW = Ops
) (
   input  logic [2:0]     opcode,
   output logic           legal,
   output logic [OpW-1:0] alu_op,
   output logic           force_a_zero,
   output logic           mask_b
);

   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      legal        = 1'b1;
      alu_op       = '0;
      force_a_zero = 1'b0;
      mask_b       = 1'b0;
      case (opcode)
         ADD, SHR, SHL: alu_op = OpW'(opcode[1:0]);
         PAR: begin
            alu_op = OpW'(opcode[1:0]);
            mask_b = 1'b1;
         end
         MOV:     force_a_zero = 1'b1;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: reads two registers, drives an external ALU,
// writes the result back and keeps the flags of the last executed instruction.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int W   = alu_pkg::W,
   parameter int Ops = alu_pkg::Ops,
   parameter int RA  = 3
) (
   input  logic           Clk,
   input  logic           Reset_n,
   input  logic           InstValid,
   input  logic [8:0]     Inst,
   output logic           InstReady,
   output logic [RA-1:0]  RfAddr,
   input  logic [W-1:0]   RfRdData,
   output logic           RfWe,
   output logic [RA-1:0]  RfWaddr,
   output logic [W-1:0]   RfWdata,
   output logic [W-1:0]   AluA,
   output logic [W-1:0]   AluB,
   output logic [Ops-1:0] AluOp,
   input  logic [W-1:0]   AluOut,
   input  logic           AluZero,
   input  logic           AluSign,
   output logic           ZeroFlag,
   output logic           SignFlag,
   output logic           Done,
   output logic           Illegal
);

   // Shift amount for parity-to-bit is reduced to a bit index inside the word.
   localparam logic [W-1:0] B_MASK = W'((1 << $clog2(W)) - 1);

   state_e         state_q, state_d;
   logic [8:0]     inst_q, inst_d;
   logic [W-1:0]   opa_q, opa_d, opb_q, opb_d, res_q, res_d;
   logic           res_zero_q, res_zero_d, res_sign_q, res_sign_d;
   logic           zero_flag_q, zero_flag_d, sign_flag_q, sign_flag_d;
   logic           ready_q, ready_d, done_q, done_d, illegal_q, illegal_d;

   logic [2:0]     dec_opcode;
   logic           dec_legal, dec_force_a_zero, dec_mask_b;
   logic [Ops-1:0] dec_alu_op;

   // Legality is judged on the offered instruction; execution uses the latched one.
   assign dec_opcode = (state_q == IDLE) ? Inst[8:6] : inst_q[8:6];

   alu_inst_decode #(.OpW(Ops)) u_decode (
      .opcode       (dec_opcode),
      .legal        (dec_legal),
      .alu_op       (dec_alu_op),
      .force_a_zero (dec_force_a_zero),
      .mask_b       (dec_mask_b)
   );

   always_comb begin
      state_d     = state_q;
      inst_d      = inst_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      res_d       = res_q;
      res_zero_d  = res_zero_q;
      res_sign_d  = res_sign_q;
      zero_flag_d = zero_flag_q;
      sign_flag_d = sign_flag_q;
      case (state_q)
         IDLE: begin
            if (ready_q && InstValid) begin
               inst_d  = Inst;
               state_d = dec_legal ? RD_A : ILL;
            end
         end
         RD_A: begin
            opa_d   = RfRdData;
            state_d = RD_B;
         end
         RD_B: begin
            opb_d   = RfRdData;
            state_d = EXEC;
         end
         EXEC: begin
            res_d      = AluOut;
            res_zero_d = AluZero;
            res_sign_d = AluSign;
            state_d    = WB;
         end
         WB: begin
            zero_flag_d = res_zero_q;
            sign_flag_d = res_sign_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ready_d   = (state_d == IDLE);
      done_d    = (state_d == WB);
      illegal_d = (state_d == ILL);
   end

   // NOTE: datapath registers are reset too, so an aborted instruction leaves no trace.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         inst_q      <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         res_q       <= '0;
         res_zero_q  <= 1'b0;
         res_sign_q  <= 1'b0;
         zero_flag_q <= 1'b0;
         sign_flag_q <= 1'b0;
         ready_q     <= 1'b0;
         done_q      <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values.
         state_q     <= state_d;
         inst_q      <= inst_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         res_q       <= res_d;
         res_zero_q  <= res_zero_d;
         res_sign_q  <= res_sign_d;
         zero_flag_q <= zero_flag_d;
         sign_flag_q <= sign_flag_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         illegal_q   <= illegal_d;
      end
   end

   always_comb begin
      InstReady = ready_q;
      Done      = done_q;
      RfWe      = done_q;
      Illegal   = illegal_q;
      ZeroFlag  = zero_flag_q;
      SignFlag  = sign_flag_q;
      RfWaddr   = done_q ? RA'(inst_q[5:3]) : '0;
      RfWdata   = done_q ? res_q : '0;
      case (state_q)
         RD_A:    RfAddr = RA'(inst_q[5:3]);
         RD_B:    RfAddr = RA'(inst_q[2:0]);
         default: RfAddr = '0;
      endcase
      AluA  = '0;
      AluB  = '0;
      AluOp = '0;
      if (state_q == EXEC) begin
         AluA  = dec_force_a_zero ? '0 : opa_q;
         AluB  = dec_mask_b ? (opb_q & B_MASK) : opb_q;
         AluOp = dec_alu_op;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural register file and ALU.
module tb_alu_sequencer;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       InstValid;
   logic [8:0] Inst;
   logic       InstReady;
   logic [2:0] RfAddr;
   logic [7:0] RfRdData;
   logic       RfWe;
   logic [2:0] RfWaddr;
   logic [7:0] RfWdata;
   logic [7:0] AluA, AluB, AluOut;
   logic [2:0] AluOp;
   logic       AluZero, AluSign;
   logic       ZeroFlag, SignFlag, Done, Illegal;

   int checks = 0;
   int errors = 0;

   logic [7:0] rf [8];
   logic       tb_we;
   logic [2:0] tb_addr;
   logic [7:0] tb_data;

   int         done_total = 0;
   int         overlap_cnt = 0;

   int         done_cnt, done_k, ill_cnt, ill_k, we_cnt;
   logic [7:0] wb_data, ex_a, ex_b;
   logic [2:0] wb_addr, ex_op;
   logic       rdy_at [1:6];

   always #5 Clk = ~Clk;

   alu_sequencer dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .InstValid (InstValid),
      .Inst      (Inst),
      .InstReady (InstReady),
      .RfAddr    (RfAddr),
      .RfRdData  (RfRdData),
      .RfWe      (RfWe),
      .RfWaddr   (RfWaddr),
      .RfWdata   (RfWdata),
      .AluA      (AluA),
      .AluB      (AluB),
      .AluOp     (AluOp),
      .AluOut    (AluOut),
      .AluZero   (AluZero),
      .AluSign   (AluSign),
      .ZeroFlag  (ZeroFlag),
      .SignFlag  (SignFlag),
      .Done      (Done),
      .Illegal   (Illegal)
   );

   assign RfRdData = rf[RfAddr];

   always @(posedge Clk) begin
      if (RfWe) rf[RfWaddr] <= RfWdata;
      else if (tb_we) rf[tb_addr] <= tb_data;
   end

   // Reference ALU: shift amounts >= 8 pass A through; PAR puts parity of A at bit B.
   always_comb begin
      case (AluOp)
         3'd0:    AluOut = AluA + AluB;
         3'd1:    AluOut = (AluB >= 8'd8) ? AluA : (AluA >> AluB);
         3'd2:    AluOut = (AluB >= 8'd8) ? AluA : (AluA << AluB);
         3'd3:    AluOut = {7'b0, ^AluA} << AluB[2:0];
         default: AluOut = '0;
      endcase
      AluZero = (AluOut == 8'h00);
      AluSign = AluOut[7];
   end

   always @(negedge Clk) begin
      if (Done) done_total++;
      if (InstReady && (RfWe || Done || Illegal)) overlap_cnt++;
   end

   task automatic rf_load(input logic [2:0] a, input logic [7:0] d);
      @(negedge Clk);
      tb_we = 1'b1; tb_addr = a; tb_data = d;
      @(negedge Clk);
      tb_we = 1'b0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs);
      int w;
      done_cnt = 0; done_k = 0; ill_cnt = 0; ill_k = 0; we_cnt = 0;
      wb_data = '0; wb_addr = '0;
      @(negedge Clk);
      InstValid = 1'b1;
      Inst = {op, rd, rs};
      w = 0;
      while (!InstReady && w < 20) begin
         @(negedge Clk);
         w++;
      end
      if (!InstReady) begin
         checks++; errors++;
         $display("FAIL accept_timeout: InstReady=%0b required 1", InstReady);
         InstValid = 1'b0;
         return;
      end
      @(posedge Clk);
      #1 InstValid = 1'b0;
      Inst = '0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge Clk);
         rdy_at[k] = InstReady;
         if (k == 3) begin
            ex_a = AluA; ex_b = AluB; ex_op = AluOp;
         end
         if (Done) begin
            done_cnt++; done_k = k; wb_data = RfWdata; wb_addr = RfWaddr;
         end
         if (RfWe) we_cnt++;
         if (Illegal) begin
            ill_cnt++; ill_k = k;
         end
      end
   endtask

   task automatic test_reset;
      logic [37:0] outs;
      Reset_n = 1'b0; InstValid = 1'b0; Inst = '0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
      repeat (3) @(negedge Clk);
      outs = {RfAddr, RfWe, RfWaddr, RfWdata, AluA, AluB, AluOp, ZeroFlag, SignFlag, Done, Illegal};
      checks++;
      if (outs !== 38'h0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;
      checks++;
      if (InstReady !== 1'b1) begin
         errors++; $display("FAIL reset_ready: InstReady=%0b expected 1", InstReady);
      end
   endtask

   task automatic test_add;
      rf_load(3'd1, 8'h7F);
      rf_load(3'd2, 8'h81);
      issue(3'b000, 3'd1, 3'd2);
      checks++;
      if (done_cnt !== 1) begin errors++; $display("FAIL add_done_count: got %0d expected 1", done_cnt); end
      checks++;
      if (done_k !== 4) begin errors++; $display("FAIL add_done_cycle: got %0d expected 4", done_k); end
      checks++;
      if (wb_addr !== 3'd1 || wb_data !== 8'h00) begin
         errors++; $display("FAIL add_writeback: got addr %0d data %h expected addr 1 data 00", wb_addr, wb_data);
      end
      checks++;
      if (rf[1] !== 8'h00) begin errors++; $display("FAIL add_rf1: got %h expected 00", rf[1]); end
      checks++;
      if (ZeroFlag !== 1'b1 || SignFlag !== 1'b0) begin
         errors++; $display("FAIL add_flags: got Z%0b S%0b expected Z1 S0", ZeroFlag, SignFlag);
      end
      checks++;
      if (rdy_at[4] !== 1'b0 || rdy_at[5] !== 1'b1) begin
         errors++; $display("FAIL add_ready: got c4=%0b c5=%0b expected c4=0 c5=1", rdy_at[4], rdy_at[5]);
      end
   endtask

   task automatic test_shl;
      rf_load(3'd3, 8'h01);
      rf_load(3'd4, 8'h03);
      issue(3'b010, 3'd3, 3'd4);
      checks++;
      if (ex_a !== 8'h01 || ex_b !== 8'h03 || ex_op !== 3'd2) begin
         errors++; $display("FAIL shl_exec: got A %h B %h op %0d expected A 01 B 03 op 2", ex_a, ex_b, ex_op);
      end
      checks++;
      if (rf[3] !== 8'h08) begin errors++; $display("FAIL shl_rf3: got %h expected 08", rf[3]); end
      checks++;
      if (ZeroFlag !== 1'b0) begin errors++; $display("FAIL shl_zero: got %0b expected 0", ZeroFlag); end
   endtask

   task automatic test_par;
      rf_load(3'd5, 8'h07);
      rf_load(3'd6, 8'h0B);
      issue(3'b011, 3'd5, 3'd6);
      checks++;
      if (ex_a !== 8'h07 || ex_b !== 8'h03 || ex_op !== 3'd3) begin
         errors++; $display("FAIL par_exec: got A %h B %h op %0d expected A 07 B 03 op 3", ex_a, ex_b, ex_op);
      end
      checks++;
      if (rf[5] !== 8'h08) begin errors++; $display("FAIL par_rf5: got %h expected 08", rf[5]); end
   endtask

   task automatic test_mov;
      rf_load(3'd0, 8'h55);
      rf_load(3'd7, 8'h80);
      issue(3'b100, 3'd0, 3'd7);
      checks++;
      if (ex_a !== 8'h00 || ex_b !== 8'h80 || ex_op !== 3'd0) begin
         errors++; $display("FAIL mov_exec: got A %h B %h op %0d expected A 00 B 80 op 0", ex_a, ex_b, ex_op);
      end
      checks++;
      if (rf[0] !== 8'h80 || SignFlag !== 1'b1 || ZeroFlag !== 1'b0) begin
         errors++; $display("FAIL mov_result: got r0 %h S%0b Z%0b expected r0 80 S1 Z0", rf[0], SignFlag, ZeroFlag);
      end
   endtask

   task automatic test_shift_overflow;
      rf_load(3'd2, 8'hF0);
      rf_load(3'd4, 8'h09);
      issue(3'b001, 3'd2, 3'd4);
      checks++;
      if (ex_b !== 8'h09 || ex_op !== 3'd1) begin
         errors++; $display("FAIL shr_big_exec: got B %h op %0d expected B 09 op 1", ex_b, ex_op);
      end
      checks++;
      if (wb_data !== 8'hF0 || rf[2] !== 8'hF0) begin
         errors++; $display("FAIL shr_big_wb: got wdata %h r2 %h expected F0 F0", wb_data, rf[2]);
      end
   endtask

   task automatic test_illegal;
      issue(3'b101, 3'd1, 3'd2);
      checks++;
      if (ill_cnt !== 1 || ill_k !== 1) begin
         errors++; $display("FAIL ill_pulse: got count %0d cycle %0d expected count 1 cycle 1", ill_cnt, ill_k);
      end
      checks++;
      if (we_cnt !== 0 || done_cnt !== 0) begin
         errors++; $display("FAIL ill_no_write: got we %0d done %0d expected 0 0", we_cnt, done_cnt);
      end
      checks++;
      if (ZeroFlag !== 1'b0 || SignFlag !== 1'b1) begin
         errors++; $display("FAIL ill_flags: got Z%0b S%0b expected Z0 S1", ZeroFlag, SignFlag);
      end
      checks++;
      if (rdy_at[2] !== 1'b1) begin errors++; $display("FAIL ill_ready: got %0b expected 1", rdy_at[2]); end
      checks++;
      if (rf[1] !== 8'h00) begin errors++; $display("FAIL ill_rf1: got %h expected 00", rf[1]); end
   endtask

   task automatic test_back_to_back;
      int acc [2];
      int accepts;
      int d0;
      logic rdy;
      rf_load(3'd3, 8'h08);
      rf_load(3'd1, 8'h40);
      rf_load(3'd4, 8'h02);
      accepts = 0; acc[0] = -1; acc[1] = -1;
      @(negedge Clk);
      d0 = done_total;
      InstValid = 1'b1;
      Inst = {3'b000, 3'd3, 3'd3};
      for (int e = 0; e < 20 && accepts < 2; e++) begin
         rdy = InstReady;
         @(posedge Clk);
         if (rdy) begin
            acc[accepts] = e;
            accepts++;
            #1;
            if (accepts == 1) Inst = {3'b001, 3'd1, 3'd4};
            else begin
               InstValid = 1'b0; Inst = '0;
            end
         end
         @(negedge Clk);
      end
      InstValid = 1'b0;
      repeat (8) @(negedge Clk);
      checks++;
      if (accepts !== 2 || acc[1] - acc[0] !== 5) begin
         errors++; $display("FAIL b2b_accept: got %0d accepts at %0d,%0d expected 2 accepts 5 apart", accepts, acc[0], acc[1]);
      end
      checks++;
      if (rf[3] !== 8'h10 || rf[1] !== 8'h10) begin
         errors++; $display("FAIL b2b_results: got r3 %h r1 %h expected 10 10", rf[3], rf[1]);
      end
      checks++;
      if (done_total - d0 !== 2) begin
         errors++; $display("FAIL b2b_done: got %0d pulses expected 2", done_total - d0);
      end
   endtask

   task automatic test_reset_abort;
      int we_seen;
      rf_load(3'd6, 8'h11);
      rf_load(3'd7, 8'h22);
      @(negedge Clk);
      InstValid = 1'b1;
      Inst = {3'b000, 3'd6, 3'd7};
      @(posedge Clk);
      #1 InstValid = 1'b0;
      Inst = '0;
      repeat (3) @(negedge Clk);
      checks++;
      if (AluOp !== 3'd0 || AluA !== 8'h11 || AluB !== 8'h22) begin
         errors++; $display("FAIL abort_exec: got A %h B %h op %0d expected A 11 B 22 op 0", AluA, AluB, AluOp);
      end
      #1 Reset_n = 1'b0;
      #1;
      checks++;
      if (AluA !== 8'h00 || AluB !== 8'h00 || RfWe !== 1'b0 || Done !== 1'b0 || SignFlag !== 1'b0) begin
         errors++; $display("FAIL abort_in_reset: got A %h B %h we %0b done %0b S%0b expected all 0", AluA, AluB, RfWe, Done, SignFlag);
      end
      we_seen = 0;
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge Clk);
         if (RfWe) we_seen++;
      end
      checks++;
      if (we_seen !== 0 || rf[6] !== 8'h11) begin
         errors++; $display("FAIL abort_no_write: got we %0d r6 %h expected 0 11", we_seen, rf[6]);
      end
      checks++;
      if (InstReady !== 1'b1 || ZeroFlag !== 1'b0) begin
         errors++; $display("FAIL abort_idle: got ready %0b Z%0b expected ready 1 Z0", InstReady, ZeroFlag);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_shl();
      test_par();
      test_mov();
      test_shift_overflow();
      test_illegal();
      test_back_to_back();
      test_reset_abort();
      checks++;
      if (overlap_cnt !== 0) begin
         errors++; $display("FAIL ready_overlap: got %0d cycles expected 0", overlap_cnt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter W, default 8: datapath width.
REQ-002 Parameter Ops, default 3: ALU opcode width.
REQ-003 Parameter RA, default 3: register-file address width.
REQ-004 Clk  in  1  single clock; all state on rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 InstValid  in  1  instruction offered.
REQ-007 Inst  in  9  [8:6] opcode, [5:3] rd (A operand and destination), [2:0] rs (B operand).
REQ-008 InstReady  out  1  sequencer can accept an instruction.
REQ-009 RfAddr  out  RA  register-file read address; read is combinational, data returns in the same cycle.
REQ-010 RfRdData  in  W  register-file read data.
REQ-011 RfWe / RfWaddr / RfWdata  out  1 / RA / W  register-file write port.
REQ-012 AluA / AluB  out  W  ALU operands; AluOp  out  Ops  ALU opcode.
REQ-013 AluOut  in  W; AluZero, AluSign  in  1  ALU result and flags.
REQ-014 ZeroFlag, SignFlag  out  1  registered flags of the last executed instruction.
REQ-015 Done  out  1  one-cycle pulse on writeback; Illegal  out  1  one-cycle pulse on rejected opcode.

Function
REQ-016 FSM states: IDLE, RD_A, RD_B, EXEC, WB, ILL.
REQ-017 IDLE: InstReady=1; InstValid=1 latches Inst; next state RD_A for a legal opcode, ILL otherwise.
REQ-018 InstReady=0 in every state other than IDLE; InstValid is ignored there.
REQ-019 Opcodes: 000 add, 001 shift right, 010 shift left, 011 parity-to-bit, 100 move (add with A forced to 0); 101-111 illegal.
REQ-020 RD_A: RfAddr=rd; RfRdData registered as opA; next state RD_B.
REQ-021 RD_B: RfAddr=rs; RfRdData registered as opB; next state EXEC.
REQ-022 EXEC: AluA=opA (0 for move), AluOp=opcode[1:0] zero-extended (000 for move), AluB=opB; AluOut, AluZero and AluSign registered; next state WB.
REQ-023 For opcode 011, AluB=opB mod W (low log2(W) bits; upper bits zeroed).
REQ-024 Shift amounts >= W pass through unmodified; the resulting ALU output is written back as returned.
REQ-025 Outside EXEC: AluA=0, AluB=0, AluOp=000.
REQ-026 WB: RfWe=1, RfWaddr=rd, RfWdata=registered result, Done=1; ZeroFlag/SignFlag take the registered values; next state IDLE.
REQ-027 ILL: Illegal=1 for one cycle; no register-file write; flags unchanged; next state IDLE.
REQ-028 Latency: acceptance edge at cycle 0 -> Done high during cycle 4; next acceptance no earlier than cycle 5.
REQ-029 rd==rs is legal; both reads return the same register value.
REQ-030 RfWe, Done and Illegal are never high in the same cycle as InstReady.

Reset
REQ-031 Reset_n low forces IDLE immediately and asynchronously, and clears opA, opB, result, the latched instruction and both flags.
REQ-032 During reset, all outputs are 0 except InstReady; InstReady=1 from the first edge after Reset_n rises.
REQ-033 Reset asserted in any state aborts the instruction; no RfWe pulse follows.

Structure
REQ-034 Shared package alu_pkg holds W, Ops, the opcode enum (ADD, SHR, SHL, PAR, MOV) and the FSM state enum.
REQ-035 One combinational sub-module, alu_inst_decode, maps the opcode to {legal, AluOp, force-A-zero, mask-B}.

Verification
REQ-036 Reset, then release -> all outputs 0 during reset; InstReady=1 after release.
REQ-037 r1=0x7F, r2=0x81; ADD rd=1 rs=2 -> r1 written 0x00 in cycle 4; ZeroFlag=1; single Done pulse.
REQ-038 r3=0x01, r4=0x03; SHL rd=3 rs=4 -> r3=0x08; ZeroFlag=0.
REQ-039 PAR with opB=0x0B -> AluB=0x03 during EXEC.
REQ-040 Opcode 101 -> one-cycle Illegal pulse; no RfWe; flags unchanged; InstReady=1 in the following cycle.
REQ-041 InstValid held high with two queued instructions -> accepts at cycles 0 and 5; Reset_n pulsed during EXEC -> no RfWe, FSM in IDLE.
